pipeline_stall_ctrl: RTL
========================

Name: pipeline_stall_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. It drives enable and flush for the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) from cache hit status, load-use detection, taken branches and halt. A small FSM drains the pipeline on halt, requests a dcache flush, then parks the core. It sits beside the datapath and is the only writer of pipeline-register enable/flush controls.

Parameters:
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
CLK  in  1  system clock
nRST  in  1  synchronous active-low reset
ihit  in  1  icache returned the instruction this cycle
dhit  in  1  dcache completed the MEM-stage access this cycle
exmem_dREN  in  1  MEM-stage instruction is a load
exmem_dWEN  in  1  MEM-stage instruction is a store
idex_memToReg  in  1  EX-stage instruction is a load
idex_regDst  in  5  EX-stage destination register (regbits_t)
ifid_rs  in  5  ID-stage rs (regbits_t)
ifid_rt  in  5  ID-stage rt (regbits_t)
branch_taken  in  1  EX stage resolved a taken branch or jump
exmem_halt  in  1  halt instruction is in MEM
memwb_halt  in  1  halt instruction is in WB
flush_done  in  1  dcache write-back flush complete
pc_en  out  1  PC may load next value
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register captures inputs
ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  register captures a bubble (all zeros) when enabled
dcache_flush_req  out  1  request dcache flush
halt_out  out  1  core halted
stall_cycles  out  CNT_W  cycles with pc_en=0 while in RUN

Behaviour:
- FSM states: RUN, DRAIN, FLUSH, HALTED. Registered, 2-bit state_t.
- While nRST=0 at a rising edge: state<=RUN, stall_cycles<=0. During the reset cycle all *_en=0, all *_flush=1, pc_en=0, dcache_flush_req=0, halt_out=0.
- Derived signals in RUN:
  - mem_busy = (exmem_dREN|exmem_dWEN) & ~dhit
  - load_use = idex_memToReg & (idex_regDst!=0) & (idex_regDst==ifid_rs | idex_regDst==ifid_rt)
- RUN outputs, strict priority (first match wins):
  1. mem_busy: pc_en=0; ifid/idex/exmem_en=0; memwb_en=1 with memwb_flush=1 (bubble into WB, no double write).
  2. branch_taken: pc_en=1; all en=1; ifid_flush=1, idex_flush=1. Takes effect even when ihit=0.
  3. load_use: pc_en=0, ifid_en=0; idex_en=1 with idex_flush=1; exmem_en=memwb_en=1.
  4. ~ihit: pc_en=0; ifid_en=1 with ifid_flush=1; downstream en=1.
  5. Otherwise: all en=1, all flush=0, pc_en=1.
- Halt in RUN: when exmem_halt=1 and not mem_busy, force pc_en=0 and ifid_flush=1, overriding rules 2-5. The next state is DRAIN.
- DRAIN: pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1, exmem_en=memwb_en=1 with exmem_flush=1. Exit to FLUSH when memwb_halt=1.
- FLUSH: all en=0; dcache_flush_req=1. Exit to HALTED when flush_done=1, sampled at the edge.
- HALTED: all en=0, dcache_flush_req=0, halt_out=1. Only reset exits.
- stall_cycles: increments by 1 each cycle in RUN with pc_en=0. It saturates at 2^CNT_W-1 with no wrap and holds its value outside RUN.
- All outputs except state and counter are combinational from state and inputs. The controller adds zero cycles of latency.

Decomposition:
- cpu_types_pkg gains stall_state_t (RUN, DRAIN, FLUSH, HALTED) and reuses regbits_t and word_t.
- One interface, pipeline_ctrl_if, bundles the ports above.
- One natural sub-module is hazard_detect: the combinational load_use and mem_busy logic. The FSM and counter stay in the top module.

Test Plan:
- Reset: hold nRST=0 for 2 cycles with all inputs 1 -> all en=0, all flush=1, halt_out=0, stall_cycles=0. After release with ihit=1 and no hazards -> all en=1, pc_en=1.
- Load-use: idex_memToReg=1, idex_regDst=5, ifid_rt=5, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1 for one cycle, stall_cycles=1. With idex_regDst=0 there is no stall.
- dcache miss: exmem_dREN=1, dhit=0 for 3 cycles, then 1 -> memwb_flush=1 and other en=0 for 3 cycles, normal on the 4th, stall_cycles=3. Asserting branch_taken during the miss has no effect until dhit.
- Branch over icache miss: branch_taken=1, ihit=0 -> pc_en=1, ifid_flush=1, idex_flush=1.
- Halt sequence: exmem_halt=1, then memwb_halt=1 next cycle, then flush_done after 4 cycles -> states go RUN→DRAIN→FLUSH→HALTED. dcache_flush_req is high for exactly 4 cycles, then halt_out=1 persists. Reset returns the FSM to RUN.
- Saturation with CNT_W=4: 20 consecutive ~ihit cycles -> stall_cycles=15.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// ----------------------------------------------------------------------------
// cpu_types_pkg
// Purpose : Shared types for the 5-stage pipeline core. This slice carries the
//           register/word types, the hazard controller FSM state and a packed
//           bundle of the pipeline-register control lines.
// Ports   : none (package)
// ----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        FLUSH  = 2'd2,
        HALTED = 2'd3
    } stall_state_t;

    // Every control line the stall controller drives, kept together so the
    // priority logic can assign whole patterns at once.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic memwb_flush;
        logic dcache_flush_req;
        logic halt_out;
    } pipe_ctrl_t;

    // Everything frozen, no bubbles, no requests.
    localparam pipe_ctrl_t CTRL_FROZEN = '0;

    // Normal flow: every stage advances.
    function automatic pipe_ctrl_t ctrl_flow();
        pipe_ctrl_t c;
        c          = CTRL_FROZEN;
        c.pc_en    = 1'b1;
        c.ifid_en  = 1'b1;
        c.idex_en  = 1'b1;
        c.exmem_en = 1'b1;
        c.memwb_en = 1'b1;
        return c;
    endfunction

    // Pattern driven while reset is held: nothing captures, all flushes high.
    function automatic pipe_ctrl_t ctrl_reset();
        pipe_ctrl_t c;
        c             = CTRL_FROZEN;
        c.ifid_flush  = 1'b1;
        c.idex_flush  = 1'b1;
        c.exmem_flush = 1'b1;
        c.memwb_flush = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl_if
// Purpose : Bundles the hazard/sequencing signals exchanged between the
//           datapath and pipeline_stall_ctrl.
// Ports   : CLK, nRST (interface inputs); modport ctrl = controller view,
//           modport dp = datapath view.
// ----------------------------------------------------------------------------
interface pipeline_ctrl_if
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input logic CLK,
    input logic nRST
);
    logic             ihit;
    logic             dhit;
    logic             exmem_dREN;
    logic             exmem_dWEN;
    logic             idex_memToReg;
    regbits_t         idex_regDst;
    regbits_t         ifid_rs;
    regbits_t         ifid_rt;
    logic             branch_taken;
    logic             exmem_halt;
    logic             memwb_halt;
    logic             flush_done;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_flush;
    logic             dcache_flush_req;
    logic             halt_out;
    logic [CNT_W-1:0] stall_cycles;

    modport ctrl (
        input  CLK, nRST, ihit, dhit, exmem_dREN, exmem_dWEN, idex_memToReg,
               idex_regDst, ifid_rs, ifid_rt, branch_taken, exmem_halt,
               memwb_halt, flush_done,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
               idex_flush, exmem_flush, memwb_flush, dcache_flush_req,
               halt_out, stall_cycles
    );

    modport dp (
        input  CLK, nRST, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               dcache_flush_req, halt_out, stall_cycles,
        output ihit, dhit, exmem_dREN, exmem_dWEN, idex_memToReg, idex_regDst,
               ifid_rs, ifid_rt, branch_taken, exmem_halt, memwb_halt,
               flush_done
    );
endinterface

// File: rtl/pipeline_stall_ctrl_hazard_detect.sv
// ----------------------------------------------------------------------------
// hazard_detect
// Purpose : Purely combinational hazard terms for the stall controller.
// Ports   : i-side  exmem_dREN/exmem_dWEN/dhit  - MEM-stage access status
//                   idex_memToReg/idex_regDst   - EX-stage load destination
//                   ifid_rs/ifid_rt             - ID-stage source registers
//           o-side  mem_busy  - MEM access outstanding this cycle
//                   load_use  - ID needs a value still being loaded in EX
// ----------------------------------------------------------------------------
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic     exmem_dREN,
    input  logic     exmem_dWEN,
    input  logic     dhit,
    input  logic     idex_memToReg,
    input  regbits_t idex_regDst,
    input  regbits_t ifid_rs,
    input  regbits_t ifid_rt,
    output logic     mem_busy,
    output logic     load_use
);
    logic w_dst_nonzero;
    logic w_src_match;

    assign mem_busy      = (exmem_dREN | exmem_dWEN) & ~dhit;

    // $zero is never a real dependency.
    assign w_dst_nonzero = (idex_regDst != '0);
    assign w_src_match   = (idex_regDst == ifid_rs) | (idex_regDst == ifid_rt);
    assign load_use      = idex_memToReg & w_dst_nonzero & w_src_match;
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_stall_ctrl
// Purpose : Central hazard and sequencing controller for the 5-stage pipeline.
//           Drives PC and pipeline-register enable/flush from cache status,
//           load-use hazards, taken branches and halt; drains the pipe on halt,
//           requests a dcache flush and then parks the core.
// Ports   : CLK, nRST (sync, active-low)
//           ihit, dhit, exmem_dREN, exmem_dWEN        - cache/memory status
//           idex_memToReg, idex_regDst, ifid_rs/rt    - load-use operands
//           branch_taken, exmem_halt, memwb_halt      - control flow / halt
//           flush_done                                - dcache flush complete
//           pc_en, *_en, *_flush                      - pipeline controls
//           dcache_flush_req, halt_out                - halt handshake/status
//           stall_cycles                              - saturating stall count
// ----------------------------------------------------------------------------
module pipeline_stall_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             idex_memToReg,
    input  logic [4:0]       idex_regDst,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             branch_taken,
    input  logic             exmem_halt,
    input  logic             memwb_halt,
    input  logic             flush_done,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             dcache_flush_req,
    output logic             halt_out,
    output logic [CNT_W-1:0] stall_cycles
);
    stall_state_t     r_state;
    stall_state_t     w_state_next;
    pipe_ctrl_t       w_ctrl;
    logic             w_mem_busy;
    logic             w_load_use;
    logic [CNT_W-1:0] r_stall_cycles;

    hazard_detect u_hazard (
        .exmem_dREN    (exmem_dREN),
        .exmem_dWEN    (exmem_dWEN),
        .dhit          (dhit),
        .idex_memToReg (idex_memToReg),
        .idex_regDst   (idex_regDst),
        .ifid_rs       (ifid_rs),
        .ifid_rt       (ifid_rt),
        .mem_busy      (w_mem_busy),
        .load_use      (w_load_use)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_ctrl       = CTRL_FROZEN;
        w_state_next = r_state;
        case (r_state)
            RUN: begin
                if (w_mem_busy) begin
                    // Let WB retire into a bubble so the stalled MEM result is
                    // not written back twice.
                    w_ctrl.memwb_en    = 1'b1;
                    w_ctrl.memwb_flush = 1'b1;
                end else begin
                    if (branch_taken) begin
                        // Redirect wins over a pending icache miss: the
                        // wrong-path fetch is squashed anyway.
                        w_ctrl            = ctrl_flow();
                        w_ctrl.ifid_flush = 1'b1;
                        w_ctrl.idex_flush = 1'b1;
                    end else if (w_load_use) begin
                        w_ctrl            = ctrl_flow();
                        w_ctrl.pc_en      = 1'b0;
                        w_ctrl.ifid_en    = 1'b0;
                        w_ctrl.idex_flush = 1'b1;
                    end else if (!ihit) begin
                        w_ctrl            = ctrl_flow();
                        w_ctrl.pc_en      = 1'b0;
                        w_ctrl.ifid_flush = 1'b1;
                    end else begin
                        w_ctrl = ctrl_flow();
                    end
                    // Halt reached MEM: stop fetching and squash whatever
                    // is behind it in ID.
                    if (exmem_halt) begin
                        w_ctrl.pc_en      = 1'b0;
                        w_ctrl.ifid_flush = 1'b1;
                        w_state_next      = DRAIN;
                    end
                end
            end
            DRAIN: begin
                w_ctrl.idex_en     = 1'b1;
                w_ctrl.idex_flush  = 1'b1;
                w_ctrl.exmem_en    = 1'b1;
                w_ctrl.exmem_flush = 1'b1;
                w_ctrl.memwb_en    = 1'b1;
                if (memwb_halt) begin
                    w_state_next = FLUSH;
                end
            end
            FLUSH: begin
                w_ctrl.dcache_flush_req = 1'b1;
                if (flush_done) begin
                    w_state_next = HALTED;
                end
            end
            HALTED: begin
                w_ctrl.halt_out = 1'b1;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
        if (!nRST) begin
            w_ctrl = ctrl_reset();
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_stall_cycles <= '0;
        end else if ((r_state == RUN) && !w_ctrl.pc_en && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign pc_en            = w_ctrl.pc_en;
    assign ifid_en          = w_ctrl.ifid_en;
    assign idex_en          = w_ctrl.idex_en;
    assign exmem_en         = w_ctrl.exmem_en;
    assign memwb_en         = w_ctrl.memwb_en;
    assign ifid_flush       = w_ctrl.ifid_flush;
    assign idex_flush       = w_ctrl.idex_flush;
    assign exmem_flush      = w_ctrl.exmem_flush;
    assign memwb_flush      = w_ctrl.memwb_flush;
    assign dcache_flush_req = w_ctrl.dcache_flush_req;
    assign halt_out         = w_ctrl.halt_out;
    assign stall_cycles     = r_stall_cycles;
endmodule
